// File: rtl/vector_load_writer.sv
// vector_load_writer
// ------------------
// Load-writeback sequencer in front of the register-file write port. It fetches
// one scalar word, or LANES strided words, from data memory. Only one request is
// outstanding at a time. It packs the words into a LANES-wide vector and issues
// exactly one register-file write per load.
//
// Ports
//   clk, rst          clock (posedge) and asynchronous active-high reset
//   start             load request, sampled only while idle
//   is_vector         1 = LANES-element vector load, 0 = scalar load
//   dst               destination register index
//   base_addr         byte address of element 0
//   stride            byte distance between consecutive elements
//   busy              high whenever a load is in progress (state != IDLE)
//   done              one-cycle pulse, coincident with we3
//   mem_re            memory read request, one cycle per element
//   mem_addr          request address, valid while mem_re is high
//   mem_rdata         read data, valid while mem_valid is high
//   mem_valid         read-data strobe, honoured only while waiting for data
//   we3, ra3, wd3     register-file write enable / index / data ([LANES-1] is the scalar lane)
//   selec_v_s_w       1 = vector file, 0 = scalar file
//   cmd               register-file command, always 3'b000
module vector_load_writer #(
  parameter int LANES = 16,
  parameter int DW    = 32,
  parameter int AW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_vector,
  input  logic [3:0]            dst,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW-1:0]         stride,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_re,
  output logic [AW-1:0]         mem_addr,
  input  logic [DW-1:0]         mem_rdata,
  input  logic                  mem_valid,
  output logic                  we3,
  output logic [3:0]            ra3,
  output logic [LANES*DW-1:0]   wd3,
  output logic                  selec_v_s_w,
  output logic [2:0]            cmd
);

  localparam int KW = $clog2(LANES);

  // One-hot encoding: every status output is a single state flop, so the
  // register-file controls are glitch-free for the whole WB cycle.
  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    REQ  = 4'b0010,
    WAIT = 4'b0100,
    WB   = 4'b1000
  } state_t;

  state_t              state, state_nxt;
  logic [KW-1:0]       k;         // current element index
  logic                is_vec_q;
  logic [3:0]          dst_q;
  logic [AW-1:0]       addr_q;    // base + k*stride, kept incrementally
  logic [AW-1:0]       stride_q;
  logic [LANES*DW-1:0] lanes_q;   // lane buffer, drives wd3 directly

  logic accept;
  logic capture;
  logic last_elem;

  assign accept    = (state == IDLE) && start;
  // mem_valid counts only in WAIT; a strobe in REQ or IDLE is stale or spurious.
  assign capture   = (state == WAIT) && mem_valid;
  assign last_elem = !is_vec_q || (k == KW'(LANES - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (mem_valid) state_nxt = last_elem ? WB : REQ;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request parameters, element walk and lane buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the lane buffer is reset, unlike a typical RAM, because it is
      // visible on wd3 and a reset must leave no data from an aborted load.
      is_vec_q <= 1'b0;
      dst_q    <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      lanes_q  <= '0;
      k        <= '0;
    end else if (accept) begin
      is_vec_q <= is_vector;
      dst_q    <= dst;
      addr_q   <= base_addr;
      stride_q <= stride;
      lanes_q  <= '0;
      k        <= '0;
    end else if (capture) begin
      if (is_vec_q) begin
        lanes_q[int'(k)*DW +: DW] <= mem_rdata;
      end else begin
        lanes_q[(LANES-1)*DW +: DW] <= mem_rdata;
      end
      if (!last_elem) begin
        k      <= k + 1'b1;
        addr_q <= addr_q + stride_q;   // wraps modulo 2^AW by design
      end
    end
  end

  assign busy        = (state != IDLE);
  assign mem_re      = (state == REQ);
  assign mem_addr    = addr_q;
  assign we3         = (state == WB);
  assign done        = (state == WB);
  assign ra3         = dst_q;
  assign wd3         = lanes_q;
  assign selec_v_s_w = is_vec_q;
  assign cmd         = 3'b000;

endmodule

// File: tb/tb_vector_load_writer.sv
module tb_vector_load_writer;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          is_vector;
  logic [3:0]    dst;
  logic [31:0]   base_addr;
  logic [31:0]   stride;
  logic          busy;
  logic          done;
  logic          mem_re;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_rdata;
  logic          mem_valid;
  logic          we3;
  logic [3:0]    ra3;
  logic [511:0]  wd3;
  logic          selec_v_s_w;
  logic [2:0]    cmd;

  always #5 clk = ~clk;

  vector_load_writer dut (
    .clk(clk), .rst(rst), .start(start), .is_vector(is_vector), .dst(dst),
    .base_addr(base_addr), .stride(stride), .busy(busy), .done(done),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .we3(we3), .ra3(ra3), .wd3(wd3),
    .selec_v_s_w(selec_v_s_w), .cmd(cmd)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Memory contents
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Cycle counter and output monitor (sampled on negedge)
  int          cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] re_addr[$];
  int          re_cyc[$];
  int          we_count = 0;
  int          we_cyc;
  logic [511:0] we_wd;
  logic [3:0]  we_ra;
  logic        we_sel;
  logic        we_done;
  logic [2:0]  we_cmd;

  always @(negedge clk) begin
    if (mem_re) begin
      re_addr.push_back(mem_addr);
      re_cyc.push_back(cyc);
    end
    if (we3) begin
      we_count++;
      we_cyc  = cyc;
      we_wd   = wd3;
      we_ra   = ra3;
      we_sel  = selec_v_s_w;
      we_done = done;
      we_cmd  = cmd;
    end
  end

  // Memory responder
  bit lat_rand  = 1'b0;
  int lat_fixed = 0;
  bit spur_en   = 1'b0;

  initial begin
    logic [31:0] a;
    int d;
    mem_valid = 1'b0;
    mem_rdata = '0;
    @(posedge clk); #1;
    forever begin
      mem_valid = 1'b0;
      if (mem_re && !rst) begin
        a = mem_addr;
        d = lat_rand ? int'($urandom_range(3)) : lat_fixed;
        if (spur_en) begin            // strobe in the same cycle as mem_re
          mem_valid = 1'b1;
          mem_rdata = 32'hBAD0_0001;
        end
        @(posedge clk); #1;
        for (int w = 0; w < d; w++) begin
          mem_valid = 1'b0;
          @(posedge clk); #1;
        end
        mem_valid = 1'b1;
        mem_rdata = mem_rd(a);
        @(posedge clk); #1;
      end else begin
        if (spur_en && !busy) begin   // strobe while idle
          mem_valid = 1'b1;
          mem_rdata = 32'hBAD0_0002;
        end
        @(posedge clk); #1;
      end
    end
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  int e0;   // value of cyc after the edge that samples start

  task automatic start_load(input bit isv, input logic [3:0] d, input logic [31:0] b,
                            input logic [31:0] s, input bit hold);
    @(negedge clk);
    is_vector = isv;
    dst       = d;
    base_addr = b;
    stride    = s;
    start     = 1'b1;
    e0        = cyc + 1;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_we(input int n_before, input string tag);
    for (int i = 0; i < 400 && we_count == n_before; i++) begin
      @(negedge clk); #1;
    end
    check({tag, "_we_seen"}, we_count, n_before + 1);
  endtask

  function automatic logic [31:0] lane(input logic [511:0] v, input int k);
    return v[k*32 +: 32];
  endfunction

  task automatic check_scalar(input string tag);
    check({tag, "_ra3"}, we_ra, 4);
    check({tag, "_sel"}, we_sel, 0);
    check({tag, "_cmd"}, we_cmd, 0);
    check({tag, "_done"}, we_done, 1);
    check({tag, "_lane15"}, lane(we_wd, 15), 32'hDEAD_BEEF);
    check({tag, "_lanes0_14_zero"}, 32'(|we_wd[479:0]), 0);
  endtask

  task automatic check_ramp(input string tag);
    for (int k = 0; k < 16; k++)
      check($sformatf("%s_lane%0d", tag, k), lane(we_wd, k), k + 1);
  endtask

  initial begin
    int rb, wb;
    logic [31:0] ea;

    rst = 1'b1; start = 1'b0; is_vector = 1'b0; dst = '0; base_addr = '0; stride = '0;
    mem[32'h100] = 32'hDEAD_BEEF;
    for (int k = 0; k < 16; k++) mem[32'h40 + 4*k] = k + 1;
    for (int k = 0; k < 16; k++) begin
      ea = 32'hFFFF_FFF8 + 32'(4*k);
      mem[ea] = ea ^ 32'h5A5A_5A5A;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_we3", we3, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_ra3", ra3, 0);
    check("rst_cmd", cmd, 0);
    rst = 1'b0;

    // 1: scalar load
    rb = re_addr.size(); wb = we_count;
    start_load(1'b0, 4'd4, 32'h100, 32'h0, 1'b0);
    wait_we(wb, "t1");
    check("t1_re_count", re_addr.size() - rb, 1);
    check("t1_addr", re_addr[rb], 32'h100);
    check("t1_re_cycle", re_cyc[rb] - e0 + 1, 1);
    check("t1_we_cycle", we_cyc - e0 + 1, 3);
    check_scalar("t1");
    @(negedge clk); #1;
    check("t1_we3_after", we3, 0);
    check("t1_busy_after", busy, 0);

    // 2: vector load, fixed latency
    rb = re_addr.size(); wb = we_count;
    start_load(1'b1, 4'd2, 32'h40, 32'h4, 1'b0);
    wait_we(wb, "t2");
    check("t2_re_count", re_addr.size() - rb, 16);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t2_addr%0d", k), re_addr[rb+k], 32'h40 + 32'(4*k));
      check($sformatf("t2_re_cyc%0d", k), re_cyc[rb+k] - e0 + 1, 1 + 2*k);
    end
    check("t2_we_cycle", we_cyc - e0 + 1, 33);
    check("t2_ra3", we_ra, 2);
    check("t2_sel", we_sel, 1);
    check("t2_cmd", we_cmd, 0);
    check_ramp("t2");

    // 3: random latency plus spurious strobes
    lat_rand = 1'b1; spur_en = 1'b1;
    repeat (3) @(negedge clk);
    rb = re_addr.size(); wb = we_count;
    start_load(1'b1, 4'd2, 32'h40, 32'h4, 1'b0);
    wait_we(wb, "t3");
    repeat (4) @(negedge clk);
    spur_en = 1'b0; lat_rand = 1'b0;
    repeat (6) @(negedge clk); #1;
    check("t3_re_count", re_addr.size() - rb, 16);
    check("t3_we_count", we_count - wb, 1);
    check("t3_last_addr", re_addr[rb+15], 32'h7C);
    check_ramp("t3");

    // 4: address wrap
    rb = re_addr.size(); wb = we_count;
    start_load(1'b1, 4'd5, 32'hFFFF_FFF8, 32'h4, 1'b0);
    wait_we(wb, "t4");
    check("t4_re_count", re_addr.size() - rb, 16);
    check("t4_addr0", re_addr[rb], 32'hFFFF_FFF8);
    check("t4_addr1", re_addr[rb+1], 32'hFFFF_FFFC);
    check("t4_addr2", re_addr[rb+2], 32'h0000_0000);
    check("t4_addr15", re_addr[rb+15], 32'h0000_0034);
    check("t4_lane2", lane(we_wd, 2), 32'h5A5A_5A5A);
    check("t4_lane15", lane(we_wd, 15), 32'h5A5A_5A6E);

    // 5: start held high across a load
    rb = re_addr.size(); wb = we_count;
    start_load(1'b1, 4'd7, 32'h40, 32'h4, 1'b1);
    wait_we(wb, "t5a");
    check("t5_re_first_load", re_addr.size() - rb, 16);
    for (int i = 0; i < 20 && re_addr.size() <= rb + 16; i++) begin
      @(negedge clk); #1;
    end
    start = 1'b0;
    check("t5_re_at_restart", re_addr.size() - rb, 17);
    check("t5_restart_cycle", re_cyc[rb+16] - e0 + 1, 35);
    wait_we(wb + 1, "t5b");
    check("t5_re_total", re_addr.size() - rb, 32);
    check("t5_ra3", we_ra, 7);
    check("t5_lane9", lane(we_wd, 9), 10);

    // 6: reset in WAIT of element 7
    repeat (2) @(negedge clk);
    lat_fixed = 3;
    rb = re_addr.size(); wb = we_count;
    start_load(1'b1, 4'd9, 32'h40, 32'h4, 1'b0);
    for (int i = 0; i < 200 && re_addr.size() < rb + 8; i++) begin
      @(negedge clk); #1;
    end
    check("t6_reached_elem7", re_addr.size() - rb, 8);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_mem_re", mem_re, 0);
    check("t6_we3", we3, 0);
    check("t6_done", done, 0);
    check("t6_mem_addr", mem_addr, 0);
    check("t6_ra3", ra3, 0);
    check("t6_sel", selec_v_s_w, 0);
    check("t6_wd3_zero", 32'(|wd3), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk); #1;
    check("t6_no_we3", we_count - wb, 0);
    lat_fixed = 0;
    rb = re_addr.size(); wb = we_count;
    start_load(1'b0, 4'd4, 32'h100, 32'h0, 1'b0);
    wait_we(wb, "t6s");
    check("t6s_addr", re_addr[rb], 32'h100);
    check("t6s_we_cycle", we_cyc - e0 + 1, 3);
    check_scalar("t6s");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_load_writer.md
Name: vector_load_writer

Overview:
- Load-writeback sequencer that drives the register-file write port (we3, ra3, wd3, selec_v_s_w, cmd).
- Fetches one scalar word, or 16 strided words, from data memory through a single-outstanding request/valid interface.
- Assembles the fetched words into a 16-lane vector and issues exactly one register-file write per load.
- Sits between the decode/issue stage and the register file, beside the ALU writeback path.

Parameters:
LANES, 16, vector lanes; lane 15 doubles as the scalar lane
DW, 32, data width per lane
AW, 32, byte address width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous active-high reset
start  in  1  load request; sampled only in IDLE
is_vector  in  1  1 = 16-lane vector load, 0 = scalar load
dst  in  4  destination register index
base_addr  in  AW  address of element 0
stride  in  AW  byte distance between consecutive elements
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, coincident with we3
mem_re  out  1  memory read request, one cycle per element
mem_addr  out  AW  request address; valid while mem_re is high
mem_rdata  in  DW  read data; valid when mem_valid is high
mem_valid  in  1  read-data strobe, at least 1 cycle after mem_re
we3  out  1  register-file write enable
ra3  out  4  register-file write index
wd3  out  LANES x DW  register-file write data; [15] is the scalar lane
selec_v_s_w  out  1  1 = vector file, 0 = scalar file
cmd  out  3  always 3'b000 (never 3'b101, which redirects the write to the scalar file)

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, mem_re, we3, selec_v_s_w = 0; mem_addr=0; ra3=0; cmd=0; lane buffer and element counter cleared. An in-flight memory response is discarded.
- States:
  - IDLE: if start=1, latch is_vector, dst, base_addr and stride; clear the lane buffer; set element counter k=0; go to REQ. If start=0, stay.
  - REQ: mem_re=1 and mem_addr=base+k*stride for exactly one cycle; go to WAIT.
  - WAIT: hold until mem_valid=1. Capture mem_rdata into the target lane. If this was the last element, go to WB; else k=k+1 and go to REQ.
  - WB: we3=1, done=1, ra3=dst, wd3=lane buffer for exactly one cycle; go to IDLE.
- Lane mapping:
  - Vector: element k goes to lane k, k=0..15. selec_v_s_w=1.
  - Scalar: a single element at base_addr goes to lane 15. Lanes 0..14 are 0. selec_v_s_w=0.
- Address arithmetic: base+k*stride, truncated modulo 2^AW; wrap-around is legal and not flagged. stride=0 reads the same address 16 times.
- Outputs are registered. ra3, wd3 and selec_v_s_w are stable for the whole WB cycle, so the register file's negedge write samples a settled value. Outside WB, we3=0 and wd3 holds the last buffer contents.
- Latency, counted from the posedge that samples start=1 in IDLE (edge 0), with mem_valid arriving in the first WAIT cycle:
  - Scalar: mem_re in cycle 1; we3/done in cycle 3.
  - Vector: mem_re in cycles 1,3,...,31; we3 in cycle 33.
  - Each extra memory wait cycle adds one cycle.
- start while busy: ignored; no queueing.
- mem_valid outside WAIT: ignored.
- mem_valid in the same cycle as mem_re: ignored; data is taken only in WAIT.
- Only one memory request is outstanding at a time.
- start asserted in the WB cycle: ignored. A new start is accepted in IDLE on the following edge, giving a minimum of 1 idle cycle between loads.

Test Plan:
1. Reset, then scalar load: dst=4, base=0x100, memory returns 0xDEADBEEF one cycle after mem_re -> mem_addr=0x100 in cycle 1; we3=1, done=1, ra3=4, selec_v_s_w=0, cmd=0, wd3[15]=0xDEADBEEF, wd3[14:0]=0 in cycle 3.
2. Vector load: dst=2, base=0x40, stride=4, mem[0x40+4k]=k+1 -> 16 mem_re pulses at 0x40,0x44,...,0x7C; single we3 in cycle 33; wd3[k]=k+1 for all k; selec_v_s_w=1; cmd=0.
3. Variable memory latency: vector load with mem_valid delayed 0..3 random cycles, plus spurious mem_valid pulses in REQ and IDLE -> lane data unchanged from test 2; exactly 16 mem_re and 1 we3; spurious pulses have no effect.
4. Address wrap: base=0xFFFFFFF8, stride=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, ..., 0x00000034.
5. start held high continuously through a vector load -> second load begins only after IDLE is re-entered; no extra mem_re while busy.
6. rst asserted in WAIT of element 7 -> outputs 0 asynchronously; no we3 is ever issued; after release, a scalar load completes per test 1 with no leftover data in lanes 0..14.
